// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin packet arbiter and its pick helper.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;

  function automatic int unsigned id_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit after ptr, wrapping PORTS-1 -> 0.
module rr_pick #(
  parameter int unsigned PORTS    = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [PORTS-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);

  logic [ID_WIDTH-1:0] w_pos;

  // ptr itself is visited last, so the last-served port has the lowest priority.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      w_pos = ID_WIDTH'((32'(ptr) + k) % PORTS);
      if (!found && req[w_pos]) begin
        idx   = w_pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin packet arbiter: merges PORTS valid/ready streams, holding each grant
// until the granted port's tlast beat transfers.
module rr_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              s_tvalid,
  output logic [PORTS-1:0]              s_tready,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [PORTS-1:0]              s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tlast,
  output logic [id_width(PORTS)-1:0]    m_tid,
  output logic                          busy
);

  localparam int unsigned ID_WIDTH = id_width(PORTS);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_pick_idx;
  logic                w_pick_found;
  logic                w_pkt_done;

  rr_pick #(
    .PORTS    (PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req   (s_tvalid),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_pkt_done = m_tvalid && m_tready && m_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_next = w_pick_found ? ST_XFER : ST_IDLE;
      ST_XFER: w_state_next = w_pkt_done ? ST_IDLE : ST_XFER;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Reset ptr to the top port so port 0 is the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= ID_WIDTH'(PORTS - 1);
    end else begin
      if (r_state == ST_IDLE && w_pick_found) begin
        r_grant <= w_pick_idx;
      end
      if (r_state == ST_XFER && w_pkt_done) begin
        r_ptr <= r_grant;
      end
    end
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    s_tready = '0;
    busy     = 1'b0;
    if (r_state == ST_XFER) begin
      m_tvalid = s_tvalid[r_grant];
      m_tdata  = s_tdata[32'(r_grant) * DATA_WIDTH +: DATA_WIDTH];
      m_tlast  = s_tlast[r_grant];
      m_tid    = r_grant;
      s_tready = PORTS'(m_tready) << r_grant;
      busy     = 1'b1;
    end
  end

endmodule
